wb_merge: RTL and testbench
===========================

WB_MERGE -- requirements
Module: wb_merge

Interface
REQ-001 Parameter XLEN, default 32, data width of register write data.
REQ-002 Parameter RFIDX_WIDTH, default 5, register index width.
REQ-003 Parameter QDEPTH, default 2, long-latency result queue depth.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset:
  clk  input  1  clock; all state updates on rising edge
  rstn  input  1  asynchronous active-low reset
  pipe_we  input  1  in-order pipeline writeback request (never stalled)
  pipe_wa  input  RFIDX_WIDTH  pipeline destination register
  pipe_wd  input  XLEN  pipeline writeback data
  lu_valid  input  1  long-latency unit result valid
  lu_wa  input  RFIDX_WIDTH  long-latency destination register
  lu_wd  input  XLEN  long-latency result data
  lu_ready  output  1  block can accept a long-latency result
  lu_issue  input  1  long-latency op issued this cycle
  lu_issue_rd  input  RFIDX_WIDTH  destination of the issued op
  rf_we  output  1  register file write enable (feeds regfile write port)
  rf_wa  output  RFIDX_WIDTH  register file write address
  rf_wd  output  XLEN  register file write data
  pending  output  32  per-register busy bits for hazard detection

Function
REQ-005 rf_we/rf_wa/rf_wd SHALL be registered; a request presented in cycle N appears on the outputs during cycle N+1 (the regfile commits it on that cycle's falling edge).
REQ-006 A pipeline request is valid when pipe_we=1 and pipe_wa!=0; pipe_wa=0 requests SHALL be dropped with no output.
REQ-007 A long-unit handshake occurs when lu_valid && lu_ready at a rising edge; lu_wa=0 results SHALL be accepted and discarded (no queue entry, no output).
REQ-008 Output selection per cycle, strict priority: (1) valid pipeline request; (2) queue head, popped; (3) accepted long-unit result bypassed directly when queue empty; (4) otherwise rf_we=0, rf_wa/rf_wd hold previous values.
REQ-009 An accepted nonzero long-unit result not selected in the same cycle SHALL be pushed to the queue tail; queue order is FIFO.
REQ-010 lu_ready SHALL be 1 iff queue occupancy < QDEPTH, computed from registered occupancy only (no combinational dependence on the same-cycle pop).
REQ-011 Occupancy counter range 0..QDEPTH; same-cycle push and pop SHALL leave occupancy unchanged; read/write pointers wrap modulo QDEPTH.
REQ-012 lu_issue && lu_issue_rd!=0 SHALL set pending[lu_issue_rd] at the rising edge.
REQ-013 pending[i] SHALL clear at the edge where a long-unit result with destination i is registered onto rf_* outputs (via queue or bypass).
REQ-014 Same-edge set and clear of one index: set SHALL win.
REQ-015 Pipeline writes SHALL NOT modify pending; pending[0] SHALL always read 0.
REQ-016 Pipeline requests are never back-pressured; under continuous pipeline writes the queue fills and lu_ready drops to 0 until a pipeline bubble.

Reset
REQ-017 While rstn=0: rf_we=0, rf_wa=0, rf_wd=0, pending=0, occupancy=0, pointers=0, lu_ready=0.
REQ-018 First rising edge after rstn deasserts: lu_ready=1; reset asserted mid-operation SHALL discard queued entries without emitting them.

Verification
REQ-019 pipe_we=1, pipe_wa=5, pipe_wd=0x1234 at cycle N -> cycle N+1 rf_we=1, rf_wa=5, rf_wd=0x1234; cycle N+2 rf_we=0.
REQ-020 lu_issue rd=7 at N; lu_valid wa=7 wd=0xAA at N+3, no pipe write -> pending[7]=1 from N+1 to N+3, rf_* = (1,7,0xAA) at N+4, pending[7]=0 at N+4.
REQ-021 Pipe writes x1..x4 continuous N..N+3; lu results wa=8 (N), wa=9 (N+1), wa=10 offered N+2 -> lu_ready=0 at N+2, wa=10 held; after bubble at N+4: x8 out N+5, x9 out N+6, wa=10 accepted N+5, out N+7.
REQ-022 pipe_wa=0 with pipe_we=1 and lu_wa=0 handshake in same cycle -> no rf_we, occupancy stays 0, pending unchanged.
REQ-023 lu_issue rd=3 at same edge the previous x3 result is output -> pending[3]=1 after the edge.
REQ-024 Queue holding 2 entries, rstn pulsed low -> all outputs 0 immediately; after release, lu_ready=1 and no queued entry ever appears on rf_*.

Source files
------------

// File: rtl/wb_merge_if.sv
// Writeback merge bus: in-order pipeline writes, long-latency results,
// issue tracking, and the merged register-file write port.
interface wb_merge_if #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5
);
    logic                   pipe_we;
    logic [RFIDX_WIDTH-1:0] pipe_wa;
    logic [XLEN-1:0]        pipe_wd;

    logic                   lu_valid;
    logic [RFIDX_WIDTH-1:0] lu_wa;
    logic [XLEN-1:0]        lu_wd;
    logic                   lu_ready;

    logic                   lu_issue;
    logic [RFIDX_WIDTH-1:0] lu_issue_rd;

    logic                   rf_we;
    logic [RFIDX_WIDTH-1:0] rf_wa;
    logic [XLEN-1:0]        rf_wd;
    logic [31:0]            pending;

    modport slave (
        input  pipe_we, pipe_wa, pipe_wd,
        input  lu_valid, lu_wa, lu_wd,
        input  lu_issue, lu_issue_rd,
        output lu_ready,
        output rf_we, rf_wa, rf_wd, pending
    );

    modport master (
        output pipe_we, pipe_wa, pipe_wd,
        output lu_valid, lu_wa, lu_wd,
        output lu_issue, lu_issue_rd,
        input  lu_ready,
        input  rf_we, rf_wa, rf_wd, pending
    );
endinterface

// File: rtl/wb_merge.sv
// Merges the never-stalled pipeline writeback with long-latency results into
// one registered regfile write port; losing long results wait in a small FIFO.
module wb_merge #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int QDEPTH      = 2
) (
    input  logic      clk,
    input  logic      rstn,
    wb_merge_if.slave bus
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(QDEPTH - 1);

    logic                   r_live;
    logic [CW-1:0]          r_count;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_wr_ptr;
    logic [RFIDX_WIDTH-1:0] r_q_wa [QDEPTH];
    logic [XLEN-1:0]        r_q_wd [QDEPTH];

    logic                   r_rf_we;
    logic [RFIDX_WIDTH-1:0] r_rf_wa;
    logic [XLEN-1:0]        r_rf_wd;
    logic [31:0]            r_pending;

    logic                   w_ready;
    logic                   w_pipe_v;
    logic                   w_lu_hs;
    logic                   w_lu_v;
    logic                   w_q_empty;
    logic                   w_pop;
    logic                   w_bypass;
    logic                   w_push;
    logic [RFIDX_WIDTH-1:0] w_clr_idx;
    logic [31:0]            w_clr_mask;
    logic [31:0]            w_set_mask;
    logic [31:0]            w_pending_nxt;
    logic [CW-1:0]          w_count_nxt;

    // r_live keeps lu_ready low throughout reset and for nothing longer.
    assign w_ready   = r_live && (r_count < FULL_CNT);
    assign w_pipe_v  = bus.pipe_we && (bus.pipe_wa != '0);
    assign w_lu_hs   = bus.lu_valid && w_ready;
    assign w_lu_v    = w_lu_hs && (bus.lu_wa != '0);
    assign w_q_empty = (r_count == '0);

    assign w_pop    = !w_pipe_v && !w_q_empty;
    assign w_bypass = !w_pipe_v && w_q_empty && w_lu_v;
    assign w_push   = w_lu_v && !w_bypass;

    assign w_clr_idx  = w_pop ? r_q_wa[r_rd_ptr] : bus.lu_wa;
    assign w_clr_mask = (w_pop || w_bypass) ? (32'd1 << w_clr_idx) : 32'd0;
    assign w_set_mask = (bus.lu_issue && (bus.lu_issue_rd != '0)) ?
                        (32'd1 << bus.lu_issue_rd) : 32'd0;

    // Set applied after clear so a same-edge reissue keeps the register busy.
    assign w_pending_nxt = ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (w_pop && !w_push)
            w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_live    <= 1'b0;
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_rf_we   <= 1'b0;
            r_rf_wa   <= '0;
            r_rf_wd   <= '0;
            r_pending <= '0;
        end else begin
            r_live    <= 1'b1;
            r_count   <= w_count_nxt;
            r_pending <= w_pending_nxt;

            if (w_push)
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

            r_rf_we <= w_pipe_v || w_pop || w_bypass;
            if (w_pipe_v) begin
                r_rf_wa <= bus.pipe_wa;
                r_rf_wd <= bus.pipe_wd;
            end else if (w_pop) begin
                r_rf_wa <= r_q_wa[r_rd_ptr];
                r_rf_wd <= r_q_wd[r_rd_ptr];
            end else if (w_bypass) begin
                r_rf_wa <= bus.lu_wa;
                r_rf_wd <= bus.lu_wd;
            end
        end
    end

    // Entry storage needs no reset; reset empties the queue via count/pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_wa[r_wr_ptr] <= bus.lu_wa;
            r_q_wd[r_wr_ptr] <= bus.lu_wd;
        end
    end

    assign bus.lu_ready = w_ready;
    assign bus.rf_we    = r_rf_we;
    assign bus.rf_wa    = r_rf_wa;
    assign bus.rf_wd    = r_rf_wd;
    assign bus.pending  = r_pending;
endmodule

// File: tb/tb_wb_merge.sv
// Directed scenarios plus randomized traffic for wb_merge, checked every cycle
// against a queue-based model of the merge and pending-bit rules.
module tb_wb_merge;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int QD   = 2;

    typedef struct {
        logic [RW-1:0]   wa;
        logic [XLEN-1:0] wd;
    } ent_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wb_merge_if #(.XLEN(XLEN), .RFIDX_WIDTH(RW)) bus ();

    wb_merge #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .QDEPTH(QD)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    ent_t            mq[$];
    logic            m_we;
    logic [RW-1:0]   m_wa;
    logic [XLEN-1:0] m_wd;
    logic [31:0]     m_pend;
    bit              m_live;
    bit              m_hs;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rf_we",    64'(bus.rf_we),    64'(m_we));
        chk("rf_wa",    64'(bus.rf_wa),    64'(m_wa));
        chk("rf_wd",    64'(bus.rf_wd),    64'(m_wd));
        chk("pending",  64'(bus.pending),  64'(m_pend));
        chk("lu_ready", 64'(bus.lu_ready), 64'(m_live && (mq.size() < QD)));
    endtask

    task automatic idle();
        bus.pipe_we     = 1'b0;
        bus.pipe_wa     = '0;
        bus.pipe_wd     = '0;
        bus.lu_valid    = 1'b0;
        bus.lu_wa       = '0;
        bus.lu_wd       = '0;
        bus.lu_issue    = 1'b0;
        bus.lu_issue_rd = '0;
    endtask

    // One clock edge: predict from the current inputs, then compare after the edge.
    task automatic cyc();
        ent_t            e;
        logic            nwe;
        logic [RW-1:0]   nwa;
        logic [XLEN-1:0] nwd;
        logic [31:0]     np;
        bit              ready, pv, lv, byp;
        int              clr;
        ready = m_live && (mq.size() < QD);
        pv    = bus.pipe_we && (bus.pipe_wa != 0);
        m_hs  = bus.lu_valid && ready;
        lv    = m_hs && (bus.lu_wa != 0);
        nwe = 1'b0; nwa = m_wa; nwd = m_wd; clr = -1; byp = 0;
        if (pv) begin
            nwe = 1'b1; nwa = bus.pipe_wa; nwd = bus.pipe_wd;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            nwe = 1'b1; nwa = e.wa; nwd = e.wd; clr = int'(e.wa);
        end else if (lv) begin
            nwe = 1'b1; nwa = bus.lu_wa; nwd = bus.lu_wd; clr = int'(bus.lu_wa); byp = 1;
        end
        if (lv && !byp) begin
            e.wa = bus.lu_wa; e.wd = bus.lu_wd;
            mq.push_back(e);
        end
        np = m_pend;
        if (clr > 0) np[clr] = 1'b0;
        if (bus.lu_issue && bus.lu_issue_rd != 0) np[bus.lu_issue_rd] = 1'b1;
        np[0] = 1'b0;
        @(posedge clk);
        #1;
        m_we = nwe; m_wa = nwa; m_wd = nwd; m_pend = np; m_live = 1;
        check_all();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        mq.delete();
        m_we = 0; m_wa = '0; m_wd = '0; m_pend = '0; m_live = 0; m_hs = 0;
        check_all();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all();
        end
        rstn = 1'b1;
    endtask

    initial begin
        int burst;
        idle();
        do_reset();
        cyc();
        chk("r018_ready_after_release", 64'(bus.lu_ready), 64'd1);

        // single pipeline write
        bus.pipe_we = 1; bus.pipe_wa = 5; bus.pipe_wd = 32'h1234;
        cyc();
        chk("r019_we", 64'(bus.rf_we), 64'd1);
        chk("r019_wa", 64'(bus.rf_wa), 64'd5);
        chk("r019_wd", 64'(bus.rf_wd), 64'h1234);
        idle();
        cyc();
        chk("r019_we_drop", 64'(bus.rf_we), 64'd0);

        // issue then bypassed result
        bus.lu_issue = 1; bus.lu_issue_rd = 7;
        cyc();
        chk("r020_pend_n1", 64'(bus.pending[7]), 64'd1);
        idle();
        cyc();
        chk("r020_pend_n2", 64'(bus.pending[7]), 64'd1);
        cyc();
        chk("r020_pend_n3", 64'(bus.pending[7]), 64'd1);
        bus.lu_valid = 1; bus.lu_wa = 7; bus.lu_wd = 32'hAA;
        cyc();
        idle();
        chk("r020_we", 64'(bus.rf_we), 64'd1);
        chk("r020_wa", 64'(bus.rf_wa), 64'd7);
        chk("r020_wd", 64'(bus.rf_wd), 64'hAA);
        chk("r020_pend_clr", 64'(bus.pending[7]), 64'd0);

        // queue fills under continuous pipeline writes
        bus.pipe_we = 1; bus.pipe_wa = 1; bus.pipe_wd = 32'h101;
        bus.lu_valid = 1; bus.lu_wa = 8; bus.lu_wd = 32'h808;
        cyc();
        bus.pipe_wa = 2; bus.pipe_wd = 32'h202;
        bus.lu_wa = 9; bus.lu_wd = 32'h909;
        cyc();
        bus.pipe_wa = 3; bus.pipe_wd = 32'h303;
        bus.lu_wa = 10; bus.lu_wd = 32'hA0A;
        chk("r021_ready_low", 64'(bus.lu_ready), 64'd0);
        cyc();
        bus.pipe_wa = 4; bus.pipe_wd = 32'h404;
        cyc();
        bus.pipe_we = 0; bus.pipe_wa = 0;
        cyc();
        chk("r021_x8_wa", 64'(bus.rf_wa), 64'd8);
        chk("r021_x8_wd", 64'(bus.rf_wd), 64'h808);
        chk("r021_ready_back", 64'(bus.lu_ready), 64'd1);
        cyc();
        bus.lu_valid = 0;
        chk("r021_x9_wa", 64'(bus.rf_wa), 64'd9);
        cyc();
        chk("r021_x10_wa", 64'(bus.rf_wa), 64'd10);
        chk("r021_x10_wd", 64'(bus.rf_wd), 64'hA0A);
        idle();
        cyc();

        // zero-destination requests on both sources
        bus.pipe_we = 1; bus.pipe_wa = 0; bus.pipe_wd = 32'hDEAD;
        bus.lu_valid = 1; bus.lu_wa = 0; bus.lu_wd = 32'hBEEF;
        cyc();
        idle();
        chk("r022_no_we", 64'(bus.rf_we), 64'd0);
        chk("r022_ready", 64'(bus.lu_ready), 64'd1);

        // reissue of x3 on the edge its previous result is written
        bus.lu_issue = 1; bus.lu_issue_rd = 3;
        cyc();
        bus.lu_valid = 1; bus.lu_wa = 3; bus.lu_wd = 32'h333;
        cyc();
        idle();
        chk("r023_wa", 64'(bus.rf_wa), 64'd3);
        chk("r023_pend3", 64'(bus.pending[3]), 64'd1);

        // reset with two entries queued
        bus.pipe_we = 1; bus.pipe_wa = 13; bus.pipe_wd = 32'hD;
        bus.lu_valid = 1; bus.lu_wa = 11; bus.lu_wd = 32'hB;
        cyc();
        bus.pipe_wa = 14; bus.lu_wa = 12; bus.lu_wd = 32'hC;
        cyc();
        idle();
        chk("r024_full", 64'(bus.lu_ready), 64'd0);
        do_reset();
        chk("r024_we_in_rst", 64'(bus.rf_we), 64'd0);
        cyc();
        chk("r024_ready", 64'(bus.lu_ready), 64'd1);
        repeat (4) begin
            cyc();
            chk("r024_no_drain", 64'(bus.rf_we), 64'd0);
        end

        // randomized traffic
        burst = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0:       burst = 20;
                    1:       burst = 60;
                    default: burst = 95;
                endcase
            end
            bus.pipe_we = ($urandom_range(0, 99) < burst);
            bus.pipe_wa = RW'($urandom_range(0, 31));
            bus.pipe_wd = $urandom;
            if (!bus.lu_valid || m_hs) begin
                bus.lu_valid = ($urandom_range(0, 99) < 50);
                bus.lu_wa    = RW'($urandom_range(0, 31));
                bus.lu_wd    = $urandom;
            end
            bus.lu_issue    = ($urandom_range(0, 99) < 30);
            bus.lu_issue_rd = RW'($urandom_range(0, 31));
            cyc();
            if ($urandom_range(0, 399) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
